inv_mix_cols_seq: RTL and testbench

//   AES InvMixColumns engine for the decrypt datapath. Column-serial, with

---
 rtl/inv_mix_cols_seq.sv | 114 +++++++++++
 tb/tb_inv_mix_cols_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_cols_seq.sv
// AES InvMixColumns engine, column-serial, with valid/ready handshakes on
// both sides. COLS_PER_CYCLE column units (1, 2 or 4) work on the latched
// state each BUSY cycle. The result is presented once all four columns are done.
module inv_mix_cols_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // With 4 columns per cycle the step truncates to 0, so the counter stays at 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  state_t       state, state_nxt;
  logic [1:0]   col;
  logic [127:0] src_reg;
  logic [127:0] res_reg;
  logic         accept;
  logic         last_col;
  logic [1:0]   unit_idx [COLS_PER_CYCLE];
  logic [31:0]  unit_res [COLS_PER_CYCLE];

  // Multiply by x in GF(2^8) mod 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one 32-bit column (byte 0 = MSB). The multiplies by
  // 09/0b/0d/0e are built from the shared x2/x4/x8 chain of each byte.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a     = c[31 - 8*i -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Column c sits at bits [127-32c -: 32], i.e. base offset 32*(3-c) = {~c, 5'b0}.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
    assign unit_idx[k] = col + 2'(k);
    assign unit_res[k] = inv_col(src_reg[{~unit_idx[k], 5'd0} +: 32]);
  end

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_col  = (col == COL_LAST);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign out_data  = res_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; in_valid is ignored while BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last_col) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Column counter: cleared on accept, advanced each BUSY cycle, wraps to 0 after the last column.
  always_ff @(posedge clk) begin
    if (rst)                 col <= 2'd0;
    else if (accept)         col <= 2'd0;
    else if (state == BUSY)  col <= col + COL_STEP;
  end

  // Source state latch; data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (accept) src_reg <= in_data;
  end

  // Result register: cleared on reset (it drives out_data), written column by column.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_reg <= '0;
    end else if (state == BUSY) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++)
        res_reg[{~unit_idx[k], 5'd0} +: 32] <= unit_res[k];
    end
  end

endmodule

// File: tb/tb_inv_mix_cols_seq.sv
// Directed bench for inv_mix_cols_seq: three instances (1, 2 and 4 columns per
// cycle) share the clock and reset. It also runs random round trips through a
// forward MixColumns model.
module tb_inv_mix_cols_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];

  int n_pass = 0;
  int n_chk  = 0;

  localparam logic [127:0] V1 = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] E1 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V2 = 128'h8e4da1bc_9fdc589d_01010101_00000000;
  localparam logic [127:0] E2 = 128'hdb135345_f20a225c_01010101_00000000;

  inv_mix_cols_seq #(.COLS_PER_CYCLE(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]));

  inv_mix_cols_seq #(.COLS_PER_CYCLE(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]));

  inv_mix_cols_seq #(.COLS_PER_CYCLE(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Forward MixColumns, used only to build round-trip stimulus.
  function automatic logic [7:0] x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = x2(a0) ^ (x2(a1) ^ a1) ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ x2(a1) ^ (x2(a2) ^ a2) ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ x2(a2) ^ (x2(a3) ^ a3);
      r[103 - 32*c -: 8] = (x2(a0) ^ a0) ^ a1 ^ a2 ^ x2(a3);
    end
    return r;
  endfunction

  // Present a block and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input int d, input logic [127:0] data);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    #1;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 128'(in_ready[d]), 128'(1));
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  // Wait for out_valid (counting edges), check latency and data, then consume.
  task automatic receive(input int d, input logic [127:0] exp, input int lat, input string tag);
    int n;
    n = 0;
    while (!out_valid[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(lat));
    chk({tag, "_data"}, out_data[d], exp);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk({tag, "_drain"}, 128'(out_valid[d]), 128'(0));
  endtask

  initial begin
    logic [127:0] s;
    int n;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("rst_out_data",  out_data[0], 128'(0));
    chk("rst_busy",      128'(busy[0]), 128'(0));
    chk("rst_in_ready",  128'(in_ready[0]), 128'(1));

    // FIPS-197 vector, then a vector of known columns.
    send(0, V1);
    chk("fips_busy", 128'(busy[0]), 128'(1));
    chk("fips_in_ready_busy", 128'(in_ready[0]), 128'(0));
    receive(0, E1, 4, "fips");
    send(0, V2);
    receive(0, E2, 4, "known");

    // Backpressure hold, then back-to-back accept in the handshake cycle.
    send(0, V1);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", 128'(n), 128'(4));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 128'(out_valid[0]), 128'(1));
      chk("bp_data", out_data[0], E1);
      chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
    end
    in_valid[0]  = 1'b1;
    in_data[0]   = V2;
    out_ready[0] = 1'b1;
    #1;
    chk("b2b_in_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    chk("b2b_busy", 128'(busy[0]), 128'(1));
    chk("b2b_valid_low", 128'(out_valid[0]), 128'(0));
    receive(0, E2, 4, "b2b");

    // Reset while BUSY with two columns done.
    send(0, V1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("midrst_out_data",  out_data[0], 128'(0));
    chk("midrst_busy",      128'(busy[0]), 128'(0));
    chk("midrst_in_ready",  128'(in_ready[0]), 128'(1));
    send(0, V2);
    receive(0, E2, 4, "post_rst");

    // in_valid pulsed with other data during BUSY is ignored.
    send(0, V1);
    in_valid[0] = 1'b1;
    in_data[0]  = V2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    receive(0, E1, 2, "ignore");

    // Wider instances: same vector, shorter latency.
    send(1, V1);
    receive(1, E1, 2, "c2_fips");
    send(2, V1);
    receive(2, E1, 1, "c4_fips");

    // Random round trips: inverse of forward mix must give back the state.
    for (int i = 0; i < 1000; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      send(1, mix_cols(s));
      receive(1, s, 2, "c2_rt");
      s = {$urandom, $urandom, $urandom, $urandom};
      send(2, mix_cols(s));
      receive(2, s, 1, "c4_rt");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
